// File: rtl/nv_nvdla_cvif_rd_os_throttle.sv
// Outstanding read-beat throttle in front of the CVIF AXI AR channel, with a one-entry AR output stage.
// Optional stall counter (stall_cnt/perf_clr) is built when NVDLA_CVIF_RD_OS_PERF_EN is defined.
module nv_nvdla_cvif_rd_os_throttle #(
  parameter int unsigned ID_W   = 8,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned CNT_W  = 9
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              in_req_valid,
  output logic              in_req_ready,
  input  logic [ID_W-1:0]   in_req_id,
  input  logic [LEN_W-1:0]  in_req_len,
  input  logic [ADDR_W-1:0] in_req_addr,
  output logic              cvif2noc_axi_ar_arvalid,
  input  logic              cvif2noc_axi_ar_arready,
  output logic [ID_W-1:0]   cvif2noc_axi_ar_arid,
  output logic [LEN_W-1:0]  cvif2noc_axi_ar_arlen,
  output logic [ADDR_W-1:0] cvif2noc_axi_ar_araddr,
  input  logic              eg2ig_axi_vld,
  input  logic [7:0]        reg2dp_rd_os_cnt,
`ifdef NVDLA_CVIF_RD_OS_PERF_EN
  input  logic              perf_clr,
  output logic [31:0]       stall_cnt,
`endif
  output logic [CNT_W-1:0]  os_cnt,
  output logic [1:0]        os_state,
  output logic              os_underflow
);

  localparam int unsigned CHK_W = 10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_BLOCKED = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  os_cnt_d;
  logic              underflow_d;
  logic              arvalid_d;
  logic [ID_W-1:0]   arid_d;
  logic [LEN_W-1:0]  arlen_d;
  logic [ADDR_W-1:0] araddr_d;

  logic [CHK_W-1:0]  need_c;
  logic [CHK_W-1:0]  limit_c;
  logic              fit_c;
  logic              free_c;
  logic              accept_c;

  // Credit check on the registered count; same-cycle returns are credited next cycle.
  assign need_c   = CHK_W'(os_cnt) + CHK_W'(in_req_len) + CHK_W'(1);
  assign limit_c  = CHK_W'(reg2dp_rd_os_cnt) + CHK_W'(1);
  assign fit_c    = (need_c <= limit_c);
  assign free_c   = !cvif2noc_axi_ar_arvalid || cvif2noc_axi_ar_arready;
  assign in_req_ready = nvdla_core_rstn && free_c && fit_c;
  assign accept_c = in_req_valid && in_req_ready;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q                 <= S_IDLE;
      os_cnt                  <= '0;
      os_underflow            <= 1'b0;
      cvif2noc_axi_ar_arvalid <= 1'b0;
      cvif2noc_axi_ar_arid    <= '0;
      cvif2noc_axi_ar_arlen   <= '0;
      cvif2noc_axi_ar_araddr  <= '0;
    end else begin
      state_q                 <= state_d;
      os_cnt                  <= os_cnt_d;
      os_underflow            <= underflow_d;
      cvif2noc_axi_ar_arvalid <= arvalid_d;
      cvif2noc_axi_ar_arid    <= arid_d;
      cvif2noc_axi_ar_arlen   <= arlen_d;
      cvif2noc_axi_ar_araddr  <= araddr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    os_cnt_d    = os_cnt;
    underflow_d = os_underflow;
    arvalid_d   = cvif2noc_axi_ar_arvalid;
    arid_d      = cvif2noc_axi_ar_arid;
    arlen_d     = cvif2noc_axi_ar_arlen;
    araddr_d    = cvif2noc_axi_ar_araddr;

    // Output stage: load on accept, drop on handshake, hold while stalled.
    if (accept_c) begin
      arvalid_d = 1'b1;
      arid_d    = in_req_id;
      arlen_d   = in_req_len;
      araddr_d  = in_req_addr;
    end else if (cvif2noc_axi_ar_arready) begin
      arvalid_d = 1'b0;
    end

    // Fit guarantees the sum never exceeds 256, so CNT_W bits cannot wrap.
    if (accept_c) begin
      os_cnt_d = os_cnt + CNT_W'(in_req_len) + CNT_W'(1) - CNT_W'(eg2ig_axi_vld);
    end else if (eg2ig_axi_vld) begin
      if (os_cnt == '0) begin
        underflow_d = 1'b1;
      end else begin
        os_cnt_d = os_cnt - CNT_W'(1);
      end
    end

    if ((os_cnt_d == '0) && !arvalid_d) begin
      state_d = S_IDLE;
    end else if (in_req_valid && !fit_c && free_c) begin
      state_d = S_BLOCKED;
    end else begin
      state_d = S_ACTIVE;
    end
  end

  assign os_state = state_q;

`ifdef NVDLA_CVIF_RD_OS_PERF_EN
  // Saturating count of cycles spent in BLOCKED; clear wins over increment.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      stall_cnt <= '0;
    end else if (perf_clr) begin
      stall_cnt <= '0;
    end else if ((state_q == S_BLOCKED) && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
